// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction memory port, pipeline control from execute, IF/ID outputs to decode.
// Latency: none, wires only.
// Backpressure: stall from downstream travels on this bus.
interface fetch_unit_if #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               stall;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  ir_pc;
    logic               ir_valid;
    logic               halted;
    logic [CNT_W-1:0]   fetch_count;

    modport master (
        output imem_addr, ir, ir_pc, ir_valid, halted, fetch_count,
        input  imem_data, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_addr, ir, ir_pc, ir_valid, halted, fetch_count,
        output imem_data, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads combinational imem, fills the IF/ID register, stops on HALT.
// Latency: 1 cycle from imem_addr to ir; a redirect costs one bubble.
// Backpressure: stall freezes PC, IF/ID and the counter; a redirect overrides stall.
module fetch_unit #(
    parameter int                  ADDR_W    = 6,
    parameter int                  INSTR_W   = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  HALT_WORD = '0,
    parameter int                  CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc, pc_nxt;
    logic [INSTR_W-1:0] ir, ir_nxt;
    logic [ADDR_W-1:0]  ir_pc, ir_pc_nxt;
    logic               ir_valid, ir_valid_nxt;
    logic [CNT_W-1:0]   fetch_count, fetch_count_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            ir          <= '0;
            ir_pc       <= '0;
            ir_valid    <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            ir          <= ir_nxt;
            ir_pc       <= ir_pc_nxt;
            ir_valid    <= ir_valid_nxt;
            fetch_count <= fetch_count_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        ir_nxt          = ir;
        ir_pc_nxt       = ir_pc;
        ir_valid_nxt    = ir_valid;
        fetch_count_nxt = fetch_count;

        if (bus.redirect_valid) begin
            pc_nxt       = bus.redirect_pc;
            ir_nxt       = '0;
            ir_valid_nxt = 1'b0;
            state_nxt    = ST_RUN;
        end else if (!bus.stall) begin
            case (state)
                ST_RUN: begin
                    ir_nxt       = bus.imem_data;
                    ir_pc_nxt    = pc;
                    ir_valid_nxt = 1'b1;
                    if (fetch_count != {CNT_W{1'b1}})
                        fetch_count_nxt = fetch_count + 1'b1;
                    // PC parks on the HALT word so a debugger sees where fetch stopped
                    if (bus.imem_data == HALT_WORD)
                        state_nxt = ST_HALT;
                    else
                        pc_nxt = pc + 1'b1;
                end
                ST_HALT: ir_valid_nxt = 1'b0;
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.ir          = ir;
    assign bus.ir_pc       = ir_pc;
    assign bus.ir_valid    = ir_valid;
    assign bus.halted      = (state == ST_HALT);
    assign bus.fetch_count = fetch_count;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed program with a reference model compared every cycle.
// Latency: model advances on each rising edge, compared on falling edges.
// Backpressure: stall and redirect are driven directly from the stimulus.
module tb_fetch_unit;
    localparam int AW = 6;
    localparam int IW = 16;
    localparam int CW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW), .CNT_W(CW)) bus ();

    logic [IW-1:0] mem [64];
    assign bus.imem_data = mem[bus.imem_addr];

    fetch_unit #(
        .ADDR_W(AW), .INSTR_W(IW), .RESET_PC(6'd0), .HALT_WORD(16'h0000), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: what decode should see, following the fetch rules edge by edge
    logic [AW-1:0] m_pc    = '0;
    logic [IW-1:0] m_ir    = '0;
    logic [AW-1:0] m_irpc  = '0;
    logic          m_vld   = 1'b0;
    logic          m_halt  = 1'b0;
    int            m_cnt   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = '0; m_ir = '0; m_irpc = '0; m_vld = 1'b0; m_halt = 1'b0; m_cnt = 0;
        end else if (bus.redirect_valid) begin
            m_pc = bus.redirect_pc; m_ir = '0; m_vld = 1'b0; m_halt = 1'b0;
        end else if (bus.stall) begin
            m_pc = m_pc;
        end else if (m_halt) begin
            m_vld = 1'b0;
        end else begin
            m_ir   = mem[m_pc];
            m_irpc = m_pc;
            m_vld  = 1'b1;
            m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            m_halt = (m_ir == 16'h0000);
            if (!m_halt) m_pc = (m_pc == 6'd63) ? 6'd0 : m_pc + 6'd1;
        end
    end

    always @(negedge clk) begin
        chk("cmp_ir",       32'(bus.ir),          32'(m_ir));
        chk("cmp_ir_pc",    32'(bus.ir_pc),       32'(m_irpc));
        chk("cmp_ir_valid", 32'(bus.ir_valid),    32'(m_vld));
        chk("cmp_halted",   32'(bus.halted),      32'(m_halt));
        chk("cmp_count",    32'(bus.fetch_count), 32'(m_cnt));
        chk("cmp_addr",     32'(bus.imem_addr),   32'(m_pc));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0] = 16'hB040; mem[1] = 16'hB210; mem[2] = 16'hC250; mem[3] = 16'hB210;
        mem[8] = 16'hA008; mem[25] = 16'h0000;

        #2;
        chk("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        chk("rst_count",    32'(bus.fetch_count), 32'd0);
        #10 rst_n = 1'b1;

        tick(); chk("c1_ir", 32'(bus.ir), 32'hB040); chk("c1_pc", 32'(bus.ir_pc), 32'd0);
        chk("c1_vld", 32'(bus.ir_valid), 32'd1);
        tick(); chk("c2_ir", 32'(bus.ir), 32'hB210); chk("c2_pc", 32'(bus.ir_pc), 32'd1);
        tick(); chk("c3_ir", 32'(bus.ir), 32'hC250); chk("c3_pc", 32'(bus.ir_pc), 32'd2);

        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ir",   32'(bus.ir),          32'hC250);
            chk("stall_addr", 32'(bus.imem_addr),   32'd3);
            chk("stall_cnt",  32'(bus.fetch_count), 32'd3);
        end
        bus.stall = 1'b0;
        tick(); chk("c4_ir", 32'(bus.ir), 32'hB210); chk("c4_pc", 32'(bus.ir_pc), 32'd3);
        chk("c4_cnt", 32'(bus.fetch_count), 32'd4);
        tick(); chk("c5_ir", 32'(bus.ir), 32'h1004);

        bus.redirect_valid = 1'b1; bus.redirect_pc = 6'd8; bus.stall = 1'b1;
        tick(); chk("rd_bubble", 32'(bus.ir_valid), 32'd0); chk("rd_addr", 32'(bus.imem_addr), 32'd8);
        bus.redirect_valid = 1'b0; bus.stall = 1'b0;
        tick(); chk("rd_ir", 32'(bus.ir), 32'hA008); chk("rd_pc", 32'(bus.ir_pc), 32'd8);
        chk("rd_cnt", 32'(bus.fetch_count), 32'd6);

        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.ir_pc == 6'd25) break;
        end
        chk("h_pc", 32'(bus.ir_pc), 32'd25); chk("h_ir", 32'(bus.ir), 32'h0000);
        chk("h_vld", 32'(bus.ir_valid), 32'd1); chk("h_halted", 32'(bus.halted), 32'd1);
        bus.stall = 1'b1;
        tick(); tick();
        chk("h_stall_vld", 32'(bus.ir_valid), 32'd1);
        bus.stall = 1'b0;
        tick(); chk("h_vld0", 32'(bus.ir_valid), 32'd0); chk("h_addr", 32'(bus.imem_addr), 32'd25);
        tick(); chk("h_stay", 32'(bus.halted), 32'd1);

        bus.redirect_valid = 1'b1; bus.redirect_pc = 6'd0;
        tick(); chk("hr_halted", 32'(bus.halted), 32'd0); chk("hr_addr", 32'(bus.imem_addr), 32'd0);
        bus.redirect_valid = 1'b0;
        tick(); chk("hr_ir", 32'(bus.ir), 32'hB040); chk("hr_pc", 32'(bus.ir_pc), 32'd0);

        mem[25] = 16'h1019;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 6'd62;
        tick(); bus.redirect_valid = 1'b0;
        tick(); chk("w62", 32'(bus.ir_pc), 32'd62);
        tick(); chk("w63", 32'(bus.ir_pc), 32'd63);
        tick(); chk("w0",  32'(bus.ir_pc), 32'd0); chk("w0_ir", 32'(bus.ir), 32'hB040);
        tick(); chk("w1",  32'(bus.ir_pc), 32'd1); chk("w_halted", 32'(bus.halted), 32'd0);

        #3 rst_n = 1'b0;
        #1;
        chk("mr_ir",     32'(bus.ir),          32'd0);
        chk("mr_ir_pc",  32'(bus.ir_pc),       32'd0);
        chk("mr_vld",    32'(bus.ir_valid),    32'd0);
        chk("mr_halted", 32'(bus.halted),      32'd0);
        chk("mr_cnt",    32'(bus.fetch_count), 32'd0);
        chk("mr_addr",   32'(bus.imem_addr),   32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick(); chk("mr_first_ir", 32'(bus.ir), 32'hB040); chk("mr_first_pc", 32'(bus.ir_pc), 32'd0);

        repeat (65540) @(posedge clk);
        #1;
        chk("sat_cnt", 32'(bus.fetch_count), 32'hFFFF);
        chk("sat_halted", 32'(bus.halted), 32'd0);
        tick(); chk("sat_stick", 32'(bus.fetch_count), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the program counter, drives the 6-bit address into the combinational instruction memory, and registers the returned 16-bit word into the IF/ID instruction register.
- Handles pipeline stall, branch/jump redirect from the execute stage, and HALT detection.
- Sits directly upstream of the instruction memory; its IF/ID outputs feed decode.

Parameters:
- ADDR_W, 6, program counter / instruction memory address width (64 words).
- INSTR_W, 16, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_WORD, 16'h0000, encoding that stops fetch.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_W  address to instruction memory; equals the PC register, no combinational path from inputs.
- imem_data  in  INSTR_W  instruction word returned combinationally for imem_addr in the same cycle.
- stall  in  1  decode/execute not ready; freeze PC and IF/ID.
- redirect_valid  in  1  taken branch/jump from execute; flush and load the new PC.
- redirect_pc  in  ADDR_W  target PC, sampled when redirect_valid=1.
- ir  out  INSTR_W  IF/ID instruction register.
- ir_pc  out  ADDR_W  address the word in ir was fetched from.
- ir_valid  out  1  ir holds a live instruction for decode.
- halted  out  1  fetch stopped on HALT_WORD.
- fetch_count  out  CNT_W  number of instructions delivered with ir_valid=1; saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, halted=0, fetch_count=0, state=RUN. Reset mid-operation discards any in-flight word immediately.
- The FSM has two states, RUN and HALT. halted=1 exactly in HALT.
- Per-edge priority is: redirect > stall > halt detection > normal fetch.
- Redirect (redirect_valid=1, any state, stall ignored):
  - pc<=redirect_pc, ir<=0, ir_valid<=0, state<=RUN.
  - First instruction from the target appears in ir one edge later. Redirect penalty is 1 bubble.
- Stall (stall=1, no redirect): pc, ir, ir_pc, ir_valid, state, fetch_count all hold.
- RUN, no stall/redirect, imem_data != HALT_WORD:
  - ir<=imem_data, ir_pc<=pc, ir_valid<=1.
  - pc<=pc+1 modulo 2^ADDR_W, so 63 wraps to 0 with no flag.
  - fetch_count += 1.
- RUN, no stall/redirect, imem_data == HALT_WORD:
  - ir<=HALT_WORD, ir_pc<=pc, ir_valid<=1, fetch_count += 1.
  - pc holds (stays at the HALT address), state<=HALT.
  - The HALT word is delivered to decode exactly once.
- HALT, no stall/redirect: ir_valid<=0, pc holds, ir/ir_pc hold, fetch_count holds. Only redirect or reset leaves HALT.
- HALT with stall=1: everything holds, including ir_valid=1 of the HALT word if it has not yet been consumed.
- fetch_count saturates at all-ones; it does not wrap.
- Latency: address to ir is 1 cycle. No combinational input-to-output paths except imem_data feeding registers only.
- redirect_pc beyond the populated memory range is legal; the memory returns 0 = HALT, and fetch halts there.

Test Plan:
- Reset then run, memory words 0..3 = B040, B210, C250, B210 -> ir sequence B040/0, B210/1, C250/2, B210/3 on cycles 1-4. ir_valid=1 from cycle 1; fetch_count=4 after cycle 4.
- Stall held 3 cycles while ir=C250 (ir_pc=2) -> ir, ir_pc, pc=3 and fetch_count frozen. On release the next edge gives ir=B210, ir_pc=3.
- Redirect to 8 with stall=1 on the same edge -> next edge ir_valid=0, pc=8. Following edge ir=memory[8], ir_pc=8, with exactly 1 bubble.
- Word 0000 at address 25 -> ir=0000, ir_pc=25, ir_valid=1 for one cycle, then halted=1, ir_valid=0, pc stays 25. A later redirect_pc=0 clears halted and resumes at 0.
- PC wrap: memory fully non-zero, run from 62 -> ir_pc 62, 63, 0, 1 with no halt. Preload fetch_count near max -> sticks at FFFF.
- Assert rst_n=0 mid-stream, between clock edges -> all outputs zero immediately. After release, the first fetch is from RESET_PC.
